sram_ctrl_32: RTL

//  Sequencer between the 32-bit CPU native memory bus (valid/ready/wstrb) and the external
//  512KB async SRAM (256K x 16, CS_n/OE_n/WE_n, no byte lanes).

---
 rtl/sram_ctrl_32.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl_32.sv
// sram_ctrl_32: sequences 32-bit CPU bus accesses onto a 256K x 16 async SRAM.
// Each word becomes up to two halfword cycles (lo then hi); partial-halfword
// writes are done as read-modify-write. All SRAM pins are driven from flops.
module sram_ctrl_32 #(
    parameter int ADDR_WIDTH = 18,
    parameter int RD_CYCLES  = 2,
    parameter int WE_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]           sram_data_out,
    output logic                  sram_data_oe,
    input  logic [15:0]           sram_data_in,
    output logic                  sram_cs_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_TURN, S_WSETUP, S_WPULSE, S_WHOLD, S_DONE
    } state_t;

    // What a halfword needs, decided once from its strobe pair.
    typedef enum logic [1:0] {P_SKIP, P_RD, P_WR, P_RMW} plan_t;

    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
    localparam logic [7:0] WE_LAST = 8'(WE_CYCLES - 1);

    function automatic plan_t half_plan(input logic is_read, input logic [1:0] strb);
        if (is_read)             return P_RD;
        else if (strb == 2'b11)  return P_WR;
        else if (strb == 2'b00)  return P_SKIP;
        else                     return P_RMW;
    endfunction

    function automatic state_t first_state(input plan_t p);
        return (p == P_WR) ? S_WSETUP : S_RD;
    endfunction

    state_t                  state_q, state_d;
    logic                    half_q, half_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    block_q, block_d;
    logic [ADDR_WIDTH-2:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    plan_t                   plan_lo_q, plan_lo_d, plan_hi_q, plan_hi_d;
    logic [15:0]             cap_q, cap_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [15:0]             data_out_q, data_out_d;
    logic                    cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                    data_oe_q, data_oe_d, ready_q, ready_d;

    logic                    accept;
    logic [ADDR_WIDTH-2:0]   cur_addr;
    logic [31:0]             cur_wdata;
    logic [3:0]              cur_wstrb;
    plan_t                   cur_lo, cur_hi, cur_plan;
    state_t                  nh_state;
    logic                    nh_half;
    logic                    rd_last;
    logic [15:0]             wd_half;
    logic [1:0]              st_half;

    // Upper byte-address bits are decoded upstream; bits [1:0] are word offset.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+1], mem_addr[1:0]};

    // Request fields come straight from the bus in IDLE, from the latches afterwards.
    always_comb begin
        accept = (state_q == S_IDLE) && mem_valid && !block_q;
        if (state_q == S_IDLE) begin
            cur_addr  = mem_addr[ADDR_WIDTH:2];
            cur_wdata = mem_wdata;
            cur_wstrb = mem_wstrb;
            cur_lo    = half_plan(mem_wstrb == 4'b0000, mem_wstrb[1:0]);
            cur_hi    = half_plan(mem_wstrb == 4'b0000, mem_wstrb[3:2]);
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_wstrb = wstrb_q;
            cur_lo    = plan_lo_q;
            cur_hi    = plan_hi_q;
        end
        cur_plan = half_q ? plan_hi_q : plan_lo_q;
        rd_last  = (state_q == S_RD) && (cnt_q == RD_LAST);
        // After finishing a half: start the hi half unless it is skipped or already done.
        if (!half_q && plan_hi_q != P_SKIP) begin
            nh_state = first_state(plan_hi_q);
            nh_half  = 1'b1;
        end else begin
            nh_state = S_DONE;
            nh_half  = half_q;
        end
    end

    // State register: FSM state, half pointer, phase counter, post-DONE block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            half_q  <= 1'b0;
            cnt_q   <= 8'd0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end

    // Next-state logic: walks lo half then hi half through each half's plan.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        half_d  = half_q;
        cnt_d   = cnt_q + 8'd1;
        block_d = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (accept) begin
                    if (cur_lo != P_SKIP) begin
                        state_d = first_state(cur_lo);
                        half_d  = 1'b0;
                    end else begin
                        state_d = first_state(cur_hi);
                        half_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    cnt_d = 8'd0;
                    if (cur_plan == P_RMW) begin
                        state_d = S_TURN;
                    end else begin
                        state_d = nh_state;
                        half_d  = nh_half;
                    end
                end
            end
            S_TURN: begin
                state_d = S_WSETUP;
                cnt_d   = 8'd0;
            end
            S_WSETUP: begin
                state_d = S_WPULSE;
                cnt_d   = 8'd0;
            end
            S_WPULSE: begin
                if (cnt_q == WE_LAST) begin
                    state_d = S_WHOLD;
                    cnt_d   = 8'd0;
                end
            end
            S_WHOLD: begin
                state_d = nh_state;
                half_d  = nh_half;
                cnt_d   = 8'd0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output logic: pin levels for the state being entered, so they can be registered.
    always_comb begin
        cs_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
        ready_d   = 1'b0;
        case (state_d)
            S_RD:     begin cs_n_d = 1'b0; oe_n_d = 1'b0; end
            S_TURN:   begin cs_n_d = 1'b0; end
            S_WSETUP: begin cs_n_d = 1'b0; data_oe_d = 1'b1; end
            S_WPULSE: begin cs_n_d = 1'b0; data_oe_d = 1'b1; we_n_d = 1'b0; end
            S_WHOLD:  begin cs_n_d = 1'b0; data_oe_d = 1'b1; end
            S_DONE:   begin ready_d = 1'b1; end
            default:  begin end
        endcase
    end

    // Datapath: request latches, read capture, halfword address and write-data merge.
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        plan_lo_d   = plan_lo_q;
        plan_hi_d   = plan_hi_q;
        cap_d       = cap_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        data_out_d  = data_out_q;
        wd_half     = half_d ? cur_wdata[31:16] : cur_wdata[15:0];
        st_half     = half_d ? cur_wstrb[3:2]   : cur_wstrb[1:0];
        if (accept) begin
            addr_d    = cur_addr;
            wdata_d   = cur_wdata;
            wstrb_d   = cur_wstrb;
            plan_lo_d = cur_lo;
            plan_hi_d = cur_hi;
        end
        if (rd_last) begin
            cap_d = sram_data_in;
            if (half_q && plan_hi_q == P_RD) rdata_d = {sram_data_in, cap_q};
        end
        // Address only moves at the start of a half, when we_n is already high.
        if (state_d != S_IDLE && state_d != S_DONE) sram_addr_d = {cur_addr, half_d};
        // Unstrobed bytes come from the halfword captured by the RMW read.
        if (state_d == S_WSETUP)
            data_out_d = {st_half[1] ? wd_half[15:8] : cap_q[15:8],
                          st_half[0] ? wd_half[7:0]  : cap_q[7:0]};
    end

    // Datapath and pin registers; reset parks the SRAM deselected and undriven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            plan_lo_q   <= P_SKIP;
            plan_hi_q   <= P_SKIP;
            cap_q       <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            data_out_q  <= '0;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            plan_lo_q   <= plan_lo_d;
            plan_hi_q   <= plan_hi_d;
            cap_q       <= cap_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            data_out_q  <= data_out_d;
            cs_n_q      <= cs_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
        end
    end

    assign mem_ready     = ready_q;
    assign mem_rdata     = rdata_q;
    assign sram_addr     = sram_addr_q;
    assign sram_data_out = data_out_q;
    assign sram_data_oe  = data_oe_q;
    assign sram_cs_n     = cs_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;

endmodule
